// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if -- handshake/bus bundle for the UART RX deserializer.
//   master : bit sampler + consumer side (drives strobes, config, ack)
//   slave  : deserializer (drives p_data, data_valid, parity_calc, busy, overrun)
// Signals:
//   clear        synchronous abort of partial frame / overrun / data_valid
//   deser_en     one-cycle strobe, sampled_bit carries a new data bit
//   sampled_bit  serial bit from the sampler
//   data_len     bits per frame (0 or >DATA_WIDTH means DATA_WIDTH)
//   msb_first    0: first bit is LSB, 1: first bit is MSB
//   data_ack     consumer has taken p_data
//   p_data       assembled frame, right-justified
//   data_valid   unconsumed frame present
//   parity_calc  XOR of the frame bits in p_data
//   busy         frame partially received
//   overrun      sticky: frame completed while previous one unacked
interface uart_rx_deser_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 4
);
   logic                  clear;
   logic                  deser_en;
   logic                  sampled_bit;
   logic [LEN_W-1:0]      data_len;
   logic                  msb_first;
   logic                  data_ack;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  parity_calc;
   logic                  busy;
   logic                  overrun;

   modport master (
      output clear, deser_en, sampled_bit, data_len, msb_first, data_ack,
      input  p_data, data_valid, parity_calc, busy, overrun
   );

   modport slave (
      input  clear, deser_en, sampled_bit, data_len, msb_first, data_ack,
      output p_data, data_valid, parity_calc, busy, overrun
   );
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser -- collects one sampled bit per deser_en strobe into a frame
// of 1..DATA_WIDTH bits (length and bit order latched at the first bit), then
// publishes it on a registered p_data with valid/ack handshake, even-parity
// result and a sticky overrun flag.
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-low reset
//   rx   uart_rx_deser_if slave modport (strobes/config/ack in, frame out)
module uart_rx_deser #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   uart_rx_deser_if.slave        rx
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  msb_q, msb_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  acc_q, acc_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  parity_q, parity_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;

   logic                  start;
   logic [LEN_W-1:0]      eff_len;
   logic [LEN_W-1:0]      frm_len;
   logic                  frm_msb;
   logic [LEN_W-1:0]      cnt_nx;
   logic [LEN_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] sr;
   logic                  acc_nx;

   assign eff_len = (rx.data_len == '0 || rx.data_len > LEN_W'(DATA_WIDTH))
                    ? LEN_W'(DATA_WIDTH) : rx.data_len;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      msb_d    = msb_q;
      shreg_d  = shreg_q;
      acc_d    = acc_q;
      p_data_d = p_data_q;
      parity_d = parity_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;

      // A bit arriving in IDLE starts a fresh frame: use live config and a
      // cleared accumulator; otherwise continue with the latched frame.
      start   = (state_q == IDLE);
      frm_len = start ? eff_len : len_q;
      frm_msb = start ? rx.msb_first : msb_q;
      cnt_nx  = (start ? '0 : cnt_q) + LEN_W'(1);
      // k = cnt_nx-1; MSB-first lands at N-1-k = N-cnt_nx
      bit_idx = frm_msb ? (frm_len - cnt_nx) : (cnt_nx - LEN_W'(1));
      sr      = start ? '0 : shreg_q;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (bit_idx == LEN_W'(i)) sr[i] = rx.sampled_bit;
      acc_nx  = (start ? 1'b0 : acc_q) ^ rx.sampled_bit;

      if (rx.clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         shreg_d = '0;
         acc_d   = 1'b0;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         if (rx.data_ack && valid_q) valid_d = 1'b0;
         if (rx.deser_en) begin
            len_d = frm_len;
            msb_d = frm_msb;
            if (cnt_nx == frm_len) begin
               // Completion overrides the ack-clear above: new frame is valid.
               p_data_d = sr;
               parity_d = acc_nx;
               valid_d  = 1'b1;
               if (valid_q && !rx.data_ack) ovr_d = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
               shreg_d  = '0;
               acc_d    = 1'b0;
            end else begin
               state_d  = SHIFT;
               cnt_d    = cnt_nx;
               shreg_d  = sr;
               acc_d    = acc_nx;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         msb_q    <= 1'b0;
         shreg_q  <= '0;
         acc_q    <= 1'b0;
         p_data_q <= '0;
         parity_q <= 1'b0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         msb_q    <= msb_d;
         shreg_q  <= shreg_d;
         acc_q    <= acc_d;
         p_data_q <= p_data_d;
         parity_q <= parity_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign rx.p_data      = p_data_q;
   assign rx.parity_calc = parity_q;
   assign rx.data_valid  = valid_q;
   assign rx.busy        = (state_q == SHIFT);
   assign rx.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser -- directed test-plan vectors plus randomized traffic,
// checked every cycle against a queue-based frame model.
module tb_uart_rx_deser;
   localparam int DW = 8;
   localparam int LW = 4;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   uart_rx_deser_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

   uart_rx_deser #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
      .CLK (CLK),
      .RST (RST),
      .rx  (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int       m_bits[$];
   int       m_n;
   bit       m_msb;
   bit [7:0] m_pd;
   bit       m_v, m_par, m_ovr;

   function automatic int eff_len(input int l);
      return (l == 0 || l > DW) ? DW : l;
   endfunction

   task automatic model_reset();
      m_bits.delete();
      m_pd = '0; m_v = 0; m_par = 0; m_ovr = 0;
   endtask

   task automatic model_step(input bit en, input bit b, input bit ack, input bit clr);
      bit done;
      int v, ones;
      done = 0;
      if (clr) begin
         m_bits.delete();
         m_v = 0;
         m_ovr = 0;
      end else begin
         if (en) begin
            if (m_bits.size() == 0) begin
               m_n   = eff_len(int'(bus.data_len));
               m_msb = bus.msb_first;
            end
            m_bits.push_back(int'(b));
            if (m_bits.size() == m_n) begin
               v = 0; ones = 0;
               foreach (m_bits[k]) if (m_bits[k] != 0) begin
                  v += 1 << (m_msb ? m_n - 1 - k : k);
                  ones++;
               end
               if (m_v && !ack) m_ovr = 1;
               m_pd  = v[7:0];
               m_par = ones[0];
               m_v   = 1;
               done  = 1;
               m_bits.delete();
            end
         end
         if (ack && m_v && !done) m_v = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".p_data"},  32'(bus.p_data),      32'(m_pd));
      chk({tag, ".valid"},   32'(bus.data_valid),  32'(m_v));
      chk({tag, ".parity"},  32'(bus.parity_calc), 32'(m_par));
      chk({tag, ".busy"},    32'(bus.busy),        32'(m_bits.size() > 0));
      chk({tag, ".overrun"}, 32'(bus.overrun),     32'(m_ovr));
   endtask

   // one clock: drive, edge, model, compare
   task automatic cyc(input bit en, input bit b, input bit ack, input bit clr);
      bus.deser_en    = en;
      bus.sampled_bit = b;
      bus.data_ack    = ack;
      bus.clear       = clr;
      @(posedge CLK);
      #1;
      model_step(en, b, ack, clr);
      check_all("cyc");
   endtask

   // seq[k] is the k-th bit on the wire
   task automatic send(input int seq, input int n, input bit ack_last);
      for (int k = 0; k < n; k++)
         cyc(1'b1, seq[k], ack_last && (k == n - 1), 1'b0);
   endtask

   initial begin
      RST = 1'b0;
      bus.clear = 0; bus.deser_en = 0; bus.sampled_bit = 0;
      bus.data_len = 4'd8; bus.msb_first = 0; bus.data_ack = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge CLK);
      RST = 1'b1;

      // LSB-first 8 bits 1,0,1,1,0,0,1,0
      send(32'h4D, 8, 0);
      chk("lsb8.p_data", 32'(bus.p_data), 32'h4D);
      chk("lsb8.parity", 32'(bus.parity_calc), 0);
      chk("lsb8.valid",  32'(bus.data_valid), 1);
      chk("lsb8.busy",   32'(bus.busy), 0);
      cyc(0, 0, 1, 0);
      chk("ack.valid", 32'(bus.data_valid), 0);

      // MSB-first 5 bits 1,0,0,1,1
      bus.data_len = 4'd5; bus.msb_first = 1;
      send(32'h19, 5, 0);
      chk("msb5.p_data", 32'(bus.p_data), 32'h13);
      chk("msb5.parity", 32'(bus.parity_calc), 1);
      cyc(0, 0, 1, 0);

      // back-to-back, no ack -> overrun
      bus.data_len = 4'd8; bus.msb_first = 0;
      send(32'hA5, 8, 0);
      send(32'h3C, 8, 0);
      chk("b2b.p_data",  32'(bus.p_data), 32'h3C);
      chk("b2b.overrun", 32'(bus.overrun), 1);
      cyc(0, 0, 0, 1);
      chk("clr.overrun", 32'(bus.overrun), 0);
      // back-to-back, ack on second completion
      send(32'hA5, 8, 0);
      send(32'h3C, 8, 1);
      chk("b2back.overrun", 32'(bus.overrun), 0);
      chk("b2back.valid",   32'(bus.data_valid), 1);
      cyc(0, 0, 1, 0);

      // length 0 and 15 behave as 8; length 1
      bus.data_len = 4'd0;
      send(32'h5A, 7, 0);
      chk("len0.busy", 32'(bus.busy), 1);
      send(32'h1, 1, 0);
      chk("len0.p_data", 32'(bus.p_data), 32'hDA);
      cyc(0, 0, 1, 0);
      bus.data_len = 4'd15;
      send(32'hC3, 8, 0);
      chk("len15.p_data", 32'(bus.p_data), 32'hC3);
      cyc(0, 0, 1, 0);
      bus.data_len = 4'd1;
      send(32'h1, 1, 0);
      chk("len1.p_data", 32'(bus.p_data), 32'h01);
      chk("len1.busy",   32'(bus.busy), 0);
      cyc(0, 0, 1, 0);

      // abort by clear alongside deser_en
      bus.data_len = 4'd8;
      send(32'h3, 3, 0);
      cyc(1, 1, 0, 1);
      chk("abort.busy",   32'(bus.busy), 0);
      chk("abort.p_data", 32'(bus.p_data), 32'h01);
      send(32'hFF, 8, 0);
      chk("ff.p_data", 32'(bus.p_data), 32'hFF);
      chk("ff.parity", 32'(bus.parity_calc), 0);
      cyc(0, 0, 1, 0);

      // abort by asynchronous reset mid-frame
      send(32'h5, 3, 0);
      RST = 1'b0;
      #1;
      model_reset();
      chk("rst.p_data", 32'(bus.p_data), 0);
      chk("rst.busy",   32'(bus.busy), 0);
      check_all("rst");
      @(negedge CLK);
      RST = 1'b1;
      send(32'hFF, 8, 0);
      chk("rstff.p_data", 32'(bus.p_data), 32'hFF);
      chk("rstff.parity", 32'(bus.parity_calc), 0);
      cyc(0, 0, 1, 0);

      // config change mid-frame: bits 1,1,0,1,0,0 MSB-first, 6 bits
      bus.data_len = 4'd6; bus.msb_first = 1;
      cyc(1, 1, 0, 0);
      bus.data_len = 4'd8; bus.msb_first = 0;
      send(32'h5, 5, 0);   // 1,0,1,0,0
      chk("midchg.p_data", 32'(bus.p_data), 32'h34);
      cyc(0, 0, 1, 0);

      // randomized traffic, config churning every cycle
      for (int i = 0; i < 800; i++) begin
         bus.data_len  = 4'($urandom_range(0, 15));
         bus.msb_first = 1'($urandom_range(0, 1));
         cyc($urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
